// File: rtl/ufm_stream_seq_pkg.sv
// Shared encodings for the UFM-to-byte-stream sequencer.
package ufm_stream_pkg;

  // Runtime pass mode; the unused encoding 2'd3 behaves as one-shot.
  typedef enum logic [1:0] {
    MODE_ONESHOT    = 2'd0,
    MODE_LOOP       = 2'd1,
    MODE_LOOP_PAUSE = 2'd2
  } mode_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

endpackage

// File: rtl/ufm_stream_seq_pause_timer.sv
// Loadable down-counter that parks at zero and flags it.
module pause_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load takes precedence; otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/ufm_stream_seq.sv
// Walks a UFM byte window, fetching each byte through a request/valid
// reader port and presenting it on a ready/valid byte sink.
module ufm_stream_seq
  import ufm_stream_pkg::*;
#(
  parameter int          ADDR_W       = 15,
  parameter int unsigned START_OFFSET = 32672,
  parameter int unsigned SIZE         = 64,
  parameter int unsigned PAUSE_CYCLES = 12090000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  output logic              read_en,
  output logic [ADDR_W-1:0] ufm_addr,
  input  logic [7:0]        ufm_data,
  input  logic              ufm_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_cnt
);

  localparam int PW = $clog2(64'(PAUSE_CYCLES) + 64'd1);
  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_OFFSET);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(START_OFFSET + SIZE - 1);
  localparam logic [PW-1:0]     PAUSE_LOAD = PW'(PAUSE_CYCLES - 1);

  // Reject windows that are empty or run past the top of the address space.
  generate
    if (SIZE < 1 || (64'(START_OFFSET) + 64'(SIZE)) > (64'd1 << ADDR_W)) begin : g_bad_window
      $error("ufm_stream_seq: byte window exceeds the address range");
    end
    if (PAUSE_CYCLES < 1) begin : g_bad_pause
      $error("ufm_stream_seq: pause length must be at least one cycle");
    end
  endgenerate

  state_t            r_state;
  state_t            w_state_next;
  logic              r_read_en;
  logic              r_tx_valid;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_tx_data;
  logic [ADDR_W-1:0] r_ufm_addr;
  logic [15:0]       r_pass_cnt;

  logic              w_hs;
  logic              w_last;
  logic              w_pass_end;
  logic              w_load_pause;
  logic              w_done_next;
  logic              w_pause_zero;

  pause_timer #(
    .W (PW)
  ) u_pause_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load_pause),
    .i_load_val (PAUSE_LOAD),
    .o_zero     (w_pause_zero)
  );

  // Next-state logic; mode only matters at the end of a pass, abort overrides everything.
  always_comb begin
    w_state_next = r_state;
    w_hs         = r_tx_valid && tx_ready;
    w_last       = (r_ufm_addr == LAST_ADDR);
    w_pass_end   = 1'b0;
    w_load_pause = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (ufm_valid) w_state_next = S_SEND;
      end
      S_SEND: begin
        if (w_hs) begin
          if (w_last) begin
            w_pass_end = 1'b1;
            case (mode)
              MODE_LOOP: begin
                w_state_next = S_FETCH;
              end
              MODE_LOOP_PAUSE: begin
                w_state_next = S_PAUSE;
                w_load_pause = 1'b1;
              end
              default: begin
                w_state_next = S_IDLE;
                w_done_next  = 1'b1;
              end
            endcase
          end else begin
            w_state_next = S_FETCH;
          end
        end
      end
      S_PAUSE: begin
        if (w_pause_zero) w_state_next = S_FETCH;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (abort) begin
      w_state_next = S_IDLE;
      w_pass_end   = 1'b0;
      w_load_pause = 1'b0;
      w_done_next  = 1'b0;
    end
  end

  // State, registered status outputs, data holding register, address and pass counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_read_en  <= 1'b0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx_data  <= 8'h00;
      r_ufm_addr <= START_ADDR;
      r_pass_cnt <= 16'h0000;
    end else begin
      r_state    <= w_state_next;
      r_read_en  <= (w_state_next == S_FETCH);
      r_tx_valid <= (w_state_next == S_SEND);
      r_busy     <= (w_state_next != S_IDLE);
      r_done     <= w_done_next;
      // Late read data after an abort is dropped because the state has left FETCH.
      if (r_state == S_FETCH && ufm_valid && !abort) begin
        r_tx_data <= ufm_data;
      end
      if (abort || w_state_next == S_IDLE) begin
        r_ufm_addr <= START_ADDR;
      end else if (r_state == S_SEND && w_hs) begin
        r_ufm_addr <= w_last ? START_ADDR : r_ufm_addr + ADDR_W'(1);
      end
      if (w_pass_end) begin
        r_pass_cnt <= r_pass_cnt + 16'd1;
      end
    end
  end

  assign read_en  = r_read_en;
  assign ufm_addr = r_ufm_addr;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass_cnt = r_pass_cnt;

endmodule

// File: tb/tb_ufm_stream_seq.sv
// Directed bench for ufm_stream_seq with a 4-byte window and a 10-cycle pause.
module tb_ufm_stream_seq;

  localparam int          AW    = 15;
  localparam int unsigned START = 32672;
  localparam int unsigned SZ    = 4;
  localparam int unsigned PAUSE = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic          read_en;
  logic [AW-1:0] ufm_addr;
  logic [7:0]    ufm_data;
  logic          ufm_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;
  logic [15:0]   pass_cnt;

  // reader model and manual override
  logic          model_en;
  logic          m_valid = 1'b0;
  logic [7:0]    m_data  = 8'h00;
  int            m_lat   = 0;
  logic          man_valid;
  logic [7:0]    man_data;

  logic [7:0]    rx_q[$];
  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;

  assign ufm_valid = model_en ? m_valid : man_valid;
  assign ufm_data  = model_en ? m_data  : man_data;

  always #5 clk = ~clk;

  ufm_stream_seq #(
    .ADDR_W       (AW),
    .START_OFFSET (START),
    .SIZE         (SZ),
    .PAUSE_CYCLES (PAUSE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .read_en   (read_en),
    .ufm_addr  (ufm_addr),
    .ufm_data  (ufm_data),
    .ufm_valid (ufm_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .pass_cnt  (pass_cnt)
  );

  // Reader returns the low address byte three cycles after the request rises.
  always @(negedge clk) begin
    if (m_valid) begin
      m_valid = 1'b0;
      m_lat   = 0;
    end else if (read_en) begin
      m_lat = m_lat + 1;
      if (m_lat == 3) begin
        m_valid = 1'b1;
        m_data  = ufm_addr[7:0];
      end
    end else begin
      m_lat = 0;
    end
  end

  // Sink: record every byte whose handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      rx_q.push_back(tx_data);
      $display("tx byte %02h pass_cnt=%0d", tx_data, pass_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int done_cnt;
    int low;
    int bad;
    logic [7:0] exp_b;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; tx_ready = 1'b1;
    model_en = 1'b1; man_valid = 1'b0; man_data = 8'h00;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_read_en", 32'(read_en), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass_cnt", 32'(pass_cnt), 0);
    check("rst_addr", 32'(ufm_addr), START);
    rst = 1'b0;
    tick();

    // 1: one-shot pass
    mode = 2'd0;
    pulse_start();
    check("t1_read_en", 32'(read_en), 1);
    check("t1_busy", 32'(busy), 1);
    done_cnt = 0;
    for (int i = 0; i < 200 && !(rx_q.size() >= 4 && !busy); i++) begin
      tick();
      if (done) done_cnt++;
    end
    tick();
    if (done) done_cnt++;
    check("t1_count", 32'(rx_q.size()), 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      exp_b = 8'hA0 + 8'(i);
      check($sformatf("t1_byte%0d", i), 32'(rx_q[i]), 32'(exp_b));
    end
    check("t1_done_cnt", 32'(done_cnt), 1);
    check("t1_pass_cnt", 32'(pass_cnt), 1);
    check("t1_busy_end", 32'(busy), 0);
    check("t1_addr_end", 32'(ufm_addr), START);

    // 2: continuous loop, three passes
    rx_q.delete();
    mode = 2'd1;
    pulse_start();
    done_cnt = 0;
    for (int i = 0; i < 600 && rx_q.size() < 12; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("t2_count", 32'(rx_q.size()), 12);
    for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
      exp_b = 8'hA0 + 8'(i % 4);
      check($sformatf("t2_byte%0d", i), 32'(rx_q[i]), 32'(exp_b));
    end
    check("t2_pass_cnt", 32'(pass_cnt), 4);
    check("t2_no_done", 32'(done_cnt), 0);
    check("t2_busy", 32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t2_abort_busy", 32'(busy), 0);
    check("t2_abort_pass_cnt", 32'(pass_cnt), 4);

    // 3: loop with pause
    rx_q.delete();
    mode = 2'd2;
    pulse_start();
    wait_rx(4, 200, "t3_wait_a3");
    check("t3_last_byte", 32'(rx_q[rx_q.size()-1]), 32'h0000_00A3);
    low = 0;
    while (!read_en && low < 100) begin
      low++;
      tick();
    end
    check("t3_pause_len", 32'(low), PAUSE);
    check("t3_read_en", 32'(read_en), 1);
    check("t3_addr", 32'(ufm_addr), START);
    check("t3_pass_cnt", 32'(pass_cnt), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // 4: back-pressure
    rx_q.delete();
    mode = 2'd0;
    tx_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 50 && !tx_valid; i++) tick();
    check("t4_tx_valid", 32'(tx_valid), 1);
    check("t4_tx_data", 32'(tx_data), 32'h0000_00A0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_valid !== 1'b1 || tx_data !== 8'hA0 || read_en !== 1'b0) bad++;
    end
    check("t4_stall_bad_cycles", 32'(bad), 0);
    tx_ready = 1'b1;
    tick();
    check("t4_hs_tx_valid", 32'(tx_valid), 0);
    check("t4_hs_read_en", 32'(read_en), 1);
    check("t4_hs_addr", 32'(ufm_addr), START + 1);
    check("t4_rx_count", 32'(rx_q.size()), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // 5: abort in FETCH with late read data
    model_en = 1'b0;
    pulse_start();
    check("t5_fetch", 32'(read_en), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    man_valid = 1'b1;
    man_data = 8'h55;
    tick();
    man_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid !== 1'b0 || read_en !== 1'b0) bad++;
      tick();
    end
    check("t5_no_tx_valid", 32'(bad), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_addr", 32'(ufm_addr), START);
    check("t5_pass_cnt", 32'(pass_cnt), 5);
    model_en = 1'b1;

    // 6: asynchronous reset while in SEND
    tx_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 50 && !tx_valid; i++) tick();
    check("t6_in_send", 32'(tx_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_tx_valid", 32'(tx_valid), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_read_en", 32'(read_en), 0);
    check("t6_tx_data", 32'(tx_data), 0);
    check("t6_pass_cnt", 32'(pass_cnt), 0);
    check("t6_addr", 32'(ufm_addr), START);
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
